hv_run_sequencer: RTL and testbench
===================================

Name: hv_run_sequencer

Overview:
- Sequences one complete HPU job, replacing the ad hoc software toggling of matw/run.
- Phases: item-memory fill (drives matw and mat_a into the xorshift/core datapath), then the streaming run (drives run, addr_i, addr_j to get_ctrl/core), then output drain until the last M_AXIS beat.
- Sits between the AXI-Lite register file (start/abort/config) and the datapath in the AXIS_ACLK domain.

Parameters:
- ITEM_W, 16, width of item count and mat_a.
- ADDR_W, 20, width of addr_i/addr_j.
- TIMEOUT_W, 24, width of watchdog counter (optional feature only).

Ports:
- AXIS_ACLK  in  1  clock.
- AXIS_ARESETN  in  1  asynchronous active-low reset.
- start  in  1  single-cycle job request.
- abort  in  1  single-cycle cancel request.
- cfg_item_num  in  ITEM_W  item-memory entries to generate.
- cfg_addr_i  in  ADDR_W  outer loop bound for get_ctrl.
- cfg_addr_j  in  ADDR_W  inner loop bound for get_ctrl.
- get_fin  in  1  level from get_ctrl: all input consumed.
- out_last  in  1  M_AXIS_TVALID & M_AXIS_TREADY & M_AXIS_TLAST.
- matw  out  1  item-memory write enable.
- mat_a  out  ITEM_W  item-memory write address.
- run  out  1  datapath run enable.
- addr_i  out  ADDR_W  latched cfg_addr_i.
- addr_j  out  ADDR_W  latched cfg_addr_j.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse on normal completion.
- aborted  out  1  sticky; set by abort, cleared by the next accepted start.
- state_o  out  3  current state encoding, for status readback.

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0.
- States: IDLE=0, INIT=1, GAP=2, RUN=3, DRAIN=4, DONE=5.
- IDLE:
  - start & ~abort: latch cfg_* into internal regs and addr_i/addr_j; clear aborted.
  - Next state is INIT if cfg_item_num != 0, else GAP.
  - start while not IDLE is ignored.
- INIT:
  - matw=1; mat_a starts at 0 and increments by 1 each cycle.
  - When mat_a == item_num-1, go to GAP next cycle. Exactly item_num cycles of matw; addresses 0..item_num-1.
  - mat_a returns to 0 when leaving INIT.
- GAP: one cycle with matw=0 and run=0, so the RNG and core see matw fall before run rises. Then go to RUN.
- RUN:
  - run=1. On get_fin go to DRAIN.
  - If get_fin & out_last in the same cycle, go straight to DONE.
- DRAIN: run stays 1 (stream_enable/dst_ctrl need it). On out_last go to DONE.
- DONE: run=0; done=1 for this single cycle. Then go to IDLE.
- abort in any non-IDLE state:
  - Next state IDLE; matw/run/mat_a forced to 0 next cycle; aborted=1; no done pulse.
  - Abort wins over every simultaneous event, including a simultaneous start in IDLE (start dropped, aborted not set).
- cfg_* changes outside IDLE have no effect; latched values are held until the next accepted start.
- addr_i/addr_j hold their values after the job ends, for readback.
- mat_a counts modulo 2^ITEM_W; item_num max is 2^ITEM_W-1, so the compare always terminates.
- All outputs are registered; outputs follow the state with 1-cycle latency.

Optional Feature:
- Macro HV_SEQ_TIMEOUT_EN.
- Enabled:
  - Adds input cfg_timeout (TIMEOUT_W) and output timeout (1, sticky until next accepted start).
  - Counter is cleared on entering RUN and increments every cycle in RUN/DRAIN.
  - On reaching cfg_timeout (nonzero), behave as abort and also set timeout.
  - cfg_timeout=0 disables the watchdog.
- Disabled: no extra ports, no counter; behaviour exactly as above.

Decomposition:
- Shared package hv_pkg:
  - state enum hv_seq_state_t (3-bit encodings above).
  - ITEM_W and ADDR_W constants, reused by top and core.
- Optional sub-module hv_seq_watchdog: counter plus compare, instantiated only under HV_SEQ_TIMEOUT_EN. The FSM stays in one module.

Test Plan:
- Reset mid-INIT (item_num=1000, AXIS_ARESETN low at mat_a=400) -> all outputs 0 immediately; state_o=0.
- start, item_num=1000, addr_i=299, addr_j=2 -> matw high exactly 1000 cycles (mat_a 0..999), 1 GAP cycle, run=1. get_fin at +50 and out_last at +80 -> done pulse once, busy drops the next cycle.
- item_num=0 -> no matw cycle; IDLE->GAP->RUN. get_fin and out_last in the same cycle -> DONE directly, skipping DRAIN.
- abort during RUN -> next cycle run=0, IDLE, aborted=1, no done. Next start clears aborted.
- start while busy, and start & abort together in IDLE -> both ignored; cfg change during RUN leaves addr_i unchanged.
- HV_SEQ_TIMEOUT_EN, cfg_timeout=100, get_fin never asserted -> after 100 RUN cycles timeout=1, aborted=1, IDLE.

Source files
------------

// File: rtl/hv_run_sequencer_pkg.sv
// Shared types and sizing for the HPU run sequencer.
package hv_pkg;

    localparam int ITEM_W    = 16;
    localparam int ADDR_W    = 20;
    localparam int TIMEOUT_W = 24;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_GAP   = 3'd2,
        S_RUN   = 3'd3,
        S_DRAIN = 3'd4,
        S_DONE  = 3'd5
    } hv_seq_state_t;

endpackage

// File: rtl/hv_run_sequencer_if.sv
// Control/status and datapath bundle of the run sequencer.
// HV_SEQ_TIMEOUT_EN adds cfg_timeout/timeout.
interface hv_run_sequencer_if #(
    parameter int ITEM_W    = hv_pkg::ITEM_W,
    parameter int ADDR_W    = hv_pkg::ADDR_W
`ifdef HV_SEQ_TIMEOUT_EN
   ,parameter int TIMEOUT_W = hv_pkg::TIMEOUT_W
`endif
);
    logic              start;
    logic              abort;
    logic [ITEM_W-1:0] cfg_item_num;
    logic [ADDR_W-1:0] cfg_addr_i;
    logic [ADDR_W-1:0] cfg_addr_j;
    logic              get_fin;
    logic              out_last;
    logic              matw;
    logic [ITEM_W-1:0] mat_a;
    logic              run;
    logic [ADDR_W-1:0] addr_i;
    logic [ADDR_W-1:0] addr_j;
    logic              busy;
    logic              done;
    logic              aborted;
    logic [2:0]        state_o;
`ifdef HV_SEQ_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] cfg_timeout;
    logic                 timeout;
`endif

    modport master (
`ifdef HV_SEQ_TIMEOUT_EN
        output cfg_timeout,
        input  timeout,
`endif
        output start, abort, cfg_item_num, cfg_addr_i, cfg_addr_j, get_fin, out_last,
        input  matw, mat_a, run, addr_i, addr_j, busy, done, aborted, state_o
    );

    modport slave (
`ifdef HV_SEQ_TIMEOUT_EN
        input  cfg_timeout,
        output timeout,
`endif
        input  start, abort, cfg_item_num, cfg_addr_i, cfg_addr_j, get_fin, out_last,
        output matw, mat_a, run, addr_i, addr_j, busy, done, aborted, state_o
    );
endinterface

// File: rtl/hv_run_sequencer_watchdog.sv
// RUN/DRAIN cycle watchdog; only built with HV_SEQ_TIMEOUT_EN.
`ifdef HV_SEQ_TIMEOUT_EN
module hv_seq_watchdog #(
    parameter int TIMEOUT_W = hv_pkg::TIMEOUT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_clr,
    input  logic                 i_en,
    input  logic [TIMEOUT_W-1:0] i_limit,
    output logic                 o_expire
);
    logic [TIMEOUT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     r_cnt <= '0;
        else if (i_clr) r_cnt <= '0;
        else if (i_en)  r_cnt <= r_cnt + TIMEOUT_W'(1);
    end

    // r_cnt holds the cycles already spent, so this fires in the limit-th cycle.
    assign o_expire = i_en && (i_limit != '0) && (r_cnt == i_limit - TIMEOUT_W'(1));
endmodule
`endif

// File: rtl/hv_run_sequencer.sv
// HPU job sequencer: item-memory fill, gap, streaming run, drain, done.
// Optional watchdog abort under HV_SEQ_TIMEOUT_EN.
module hv_run_sequencer
    import hv_pkg::*;
#(
    parameter int ITEM_W    = hv_pkg::ITEM_W,
    parameter int ADDR_W    = hv_pkg::ADDR_W
`ifdef HV_SEQ_TIMEOUT_EN
   ,parameter int TIMEOUT_W = hv_pkg::TIMEOUT_W
`endif
) (
    input  logic              AXIS_ACLK,
    input  logic              AXIS_ARESETN,
    hv_run_sequencer_if.slave bus
);
    hv_seq_state_t     r_state;
    logic [ITEM_W-1:0] r_item_num;
    logic [ITEM_W-1:0] r_mat_a;
    logic [ADDR_W-1:0] r_addr_i;
    logic [ADDR_W-1:0] r_addr_j;
    logic              r_matw;
    logic              r_run;
    logic              r_busy;
    logic              r_done;
    logic              r_aborted;
    logic              w_kill;
    logic              w_accept;

    assign w_accept = (r_state == S_IDLE) && bus.start && !bus.abort;

`ifdef HV_SEQ_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] r_tmo_lim;
    logic                 r_timeout;
    logic                 w_expire;

    hv_seq_watchdog #(.TIMEOUT_W(TIMEOUT_W)) u_wdog (
        .clk      (AXIS_ACLK),
        .rst_n    (AXIS_ARESETN),
        .i_clr    (r_state == S_GAP),
        .i_en     ((r_state == S_RUN) || (r_state == S_DRAIN)),
        .i_limit  (r_tmo_lim),
        .o_expire (w_expire)
    );

    always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
        if (!AXIS_ARESETN) begin
            r_tmo_lim <= '0;
            r_timeout <= 1'b0;
        end else if (w_accept) begin
            r_tmo_lim <= bus.cfg_timeout;
            r_timeout <= 1'b0;
        end else if (r_state != S_IDLE && w_expire) begin
            r_timeout <= 1'b1;
        end
    end

    assign bus.timeout = r_timeout;
    assign w_kill      = bus.abort || w_expire;
`else
    assign w_kill      = bus.abort;
`endif

    // Outputs are registered alongside the state, so they always match state_o.
    always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
        if (!AXIS_ARESETN) begin
            r_state    <= S_IDLE;
            r_item_num <= '0;
            r_mat_a    <= '0;
            r_addr_i   <= '0;
            r_addr_j   <= '0;
            r_matw     <= 1'b0;
            r_run      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_aborted  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_item_num <= bus.cfg_item_num;
                    r_addr_i   <= bus.cfg_addr_i;
                    r_addr_j   <= bus.cfg_addr_j;
                    r_aborted  <= 1'b0;
                    r_busy     <= 1'b1;
                    r_mat_a    <= '0;
                    if (bus.cfg_item_num != '0) begin
                        r_state <= S_INIT;
                        r_matw  <= 1'b1;
                    end else begin
                        r_state <= S_GAP;
                    end
                end
                S_INIT: if (r_mat_a == r_item_num - ITEM_W'(1)) begin
                    r_state <= S_GAP;
                    r_matw  <= 1'b0;
                    r_mat_a <= '0;
                end else begin
                    r_mat_a <= r_mat_a + ITEM_W'(1);
                end
                // One idle cycle so matw falls before run rises downstream.
                S_GAP: begin
                    r_state <= S_RUN;
                    r_run   <= 1'b1;
                end
                S_RUN: if (bus.get_fin && bus.out_last) begin
                    r_state <= S_DONE;
                    r_run   <= 1'b0;
                    r_done  <= 1'b1;
                end else if (bus.get_fin) begin
                    r_state <= S_DRAIN;
                end
                S_DRAIN: if (bus.out_last) begin
                    r_state <= S_DONE;
                    r_run   <= 1'b0;
                    r_done  <= 1'b1;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_matw  <= 1'b0;
                    r_run   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_mat_a <= '0;
                end
            endcase
            // Cancel overrides whatever the state logic above decided.
            if (r_state != S_IDLE && w_kill) begin
                r_state   <= S_IDLE;
                r_matw    <= 1'b0;
                r_run     <= 1'b0;
                r_mat_a   <= '0;
                r_busy    <= 1'b0;
                r_done    <= 1'b0;
                r_aborted <= 1'b1;
            end
        end
    end

    assign bus.matw    = r_matw;
    assign bus.mat_a   = r_mat_a;
    assign bus.run     = r_run;
    assign bus.addr_i  = r_addr_i;
    assign bus.addr_j  = r_addr_j;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.aborted = r_aborted;
    assign bus.state_o = r_state;
endmodule

// File: tb/tb_hv_run_sequencer.sv
// Directed self-checking bench for hv_run_sequencer.
module tb_hv_run_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_run = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    hv_run_sequencer_if bus ();

    hv_run_sequencer dut (
        .AXIS_ACLK    (clk),
        .AXIS_ARESETN (rst_n),
        .bus          (bus)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input int items, input int ai, input int aj);
        bus.cfg_item_num = 16'(items);
        bus.cfg_addr_i   = 20'(ai);
        bus.cfg_addr_j   = 20'(aj);
        bus.start        = 1'b1;
        tick();
        bus.start        = 1'b0;
    endtask

    initial begin
        int idx, bad, guard, nrun;
        bus.start = 0; bus.abort = 0; bus.get_fin = 0; bus.out_last = 0;
        bus.cfg_item_num = 0; bus.cfg_addr_i = 0; bus.cfg_addr_j = 0;
`ifdef HV_SEQ_TIMEOUT_EN
        bus.cfg_timeout = 0;
`endif
        repeat (3) tick();
        chk("rst_state", 32'(bus.state_o), 0);
        chk("rst_busy",  32'(bus.busy), 0);
        chk("rst_matw",  32'(bus.matw), 0);
        rst_n = 1'b1;
        tick();

        // reset in the middle of item fill
        go(1000, 299, 2);
        chk("init_state", 32'(bus.state_o), 1);
        chk("init_matw",  32'(bus.matw), 1);
        chk("init_mat_a0", 32'(bus.mat_a), 0);
        repeat (400) tick();
        chk("init_mat_a400", 32'(bus.mat_a), 400);
        rst_n = 1'b0;
        #1;
        chk("arst_matw",  32'(bus.matw), 0);
        chk("arst_mat_a", 32'(bus.mat_a), 0);
        chk("arst_state", 32'(bus.state_o), 0);
        chk("arst_busy",  32'(bus.busy), 0);
        chk("arst_addr_i", 32'(bus.addr_i), 0);
        tick();
        rst_n = 1'b1;
        tick();

        // full job: 1000 fill cycles, gap, run, drain, done
        go(1000, 299, 2);
        idx = 0; bad = 0; guard = 0;
        while (bus.matw && guard < 2000) begin
            if (bus.mat_a !== 16'(idx)) bad++;
            idx++; guard++;
            tick();
        end
        chk("fill_cycles", 32'(idx), 1000);
        chk("fill_addr_seq", 32'(bad), 0);
        chk("gap_state", 32'(bus.state_o), 2);
        chk("gap_run",   32'(bus.run), 0);
        tick();
        chk("run_state", 32'(bus.state_o), 3);
        chk("run_run",   32'(bus.run), 1);
        chk("run_mat_a", 32'(bus.mat_a), 0);
        repeat (49) tick();
        bus.get_fin = 1;
        tick();
        bus.get_fin = 0;
        chk("drain_state", 32'(bus.state_o), 4);
        chk("drain_run",   32'(bus.run), 1);
        repeat (29) tick();
        chk("drain_hold", 32'(bus.state_o), 4);
        bus.out_last = 1;
        tick();
        bus.out_last = 0;
        chk("done_state", 32'(bus.state_o), 5);
        chk("done_pulse", 32'(bus.done), 1);
        chk("done_run",   32'(bus.run), 0);
        chk("done_busy",  32'(bus.busy), 1);
        tick();
        chk("end_state", 32'(bus.state_o), 0);
        chk("end_done",  32'(bus.done), 0);
        chk("end_busy",  32'(bus.busy), 0);
        chk("end_addr_i", 32'(bus.addr_i), 299);
        chk("end_addr_j", 32'(bus.addr_j), 2);

        // zero items: no fill, fin and last together skip drain
        go(0, 5, 6);
        chk("z_state", 32'(bus.state_o), 2);
        chk("z_matw",  32'(bus.matw), 0);
        chk("z_busy",  32'(bus.busy), 1);
        tick();
        chk("z_run", 32'(bus.state_o), 3);
        bus.get_fin = 1; bus.out_last = 1;
        tick();
        bus.get_fin = 0; bus.out_last = 0;
        chk("z_done_state", 32'(bus.state_o), 5);
        chk("z_done", 32'(bus.done), 1);
        tick();
        chk("z_idle", 32'(bus.state_o), 0);

        // abort during RUN
        go(3, 9, 9);
        repeat (4) tick();
        chk("ab_pre", 32'(bus.state_o), 3);
        tick();
        bus.abort = 1;
        tick();
        bus.abort = 0;
        chk("ab_state", 32'(bus.state_o), 0);
        chk("ab_run",   32'(bus.run), 0);
        chk("ab_flag",  32'(bus.aborted), 1);
        chk("ab_done",  32'(bus.done), 0);
        chk("ab_busy",  32'(bus.busy), 0);
        tick();
        chk("ab_sticky", 32'(bus.aborted), 1);

        // start together with abort in IDLE is dropped
        bus.abort = 1;
        go(0, 1, 1);
        bus.abort = 0;
        chk("sa_state", 32'(bus.state_o), 0);
        chk("sa_aborted", 32'(bus.aborted), 1);
        chk("sa_addr_i", 32'(bus.addr_i), 9);

        // accepted start clears aborted; start/cfg while busy ignored
        go(0, 77, 8);
        chk("rs_state", 32'(bus.state_o), 2);
        chk("rs_aborted", 32'(bus.aborted), 0);
        chk("rs_addr_i", 32'(bus.addr_i), 77);
        go(9, 123, 4);
        chk("busy_start_state", 32'(bus.state_o), 3);
        chk("busy_start_addr_i", 32'(bus.addr_i), 77);
        chk("busy_start_matw", 32'(bus.matw), 0);
        tick();
        chk("busy_cfg_addr_j", 32'(bus.addr_j), 8);
        bus.get_fin = 1;
        tick();
        bus.get_fin = 0;
        bus.out_last = 1;
        tick();
        bus.out_last = 0;
        chk("b_done", 32'(bus.done), 1);
        tick();
        chk("b_idle", 32'(bus.state_o), 0);
        chk("b_hold_addr_i", 32'(bus.addr_i), 77);

`ifdef HV_SEQ_TIMEOUT_EN
        // watchdog: 100 RUN cycles without get_fin
        bus.cfg_timeout = 100;
        go(0, 1, 1);
        tick();
        nrun = 0; guard = 0;
        while (bus.run && guard < 300) begin
            nrun++; guard++;
            tick();
        end
        chk("to_run_cycles", 32'(nrun), 100);
        chk("to_state",   32'(bus.state_o), 0);
        chk("to_timeout", 32'(bus.timeout), 1);
        chk("to_aborted", 32'(bus.aborted), 1);
        chk("to_done",    32'(bus.done), 0);
        go(0, 1, 1);
        chk("to_clear", 32'(bus.timeout), 0);
        bus.abort = 1;
        tick();
        bus.abort = 0;
`else
        nrun = 0;
        chk("idle_run", 32'(bus.run + 1'(nrun)), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
